// File: rtl/fiber_dram_pkg.sv
// Shared types and default widths for the fiber DRAM responder and the fiber bank.
package fiber_dram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fiber_dram_mem.sv
// Backing store: MEM_WORDS x DATA_WIDTH, synchronous write, registered read, no reset.
module fiber_dram_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WORDS  = 256
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/fiber_dram_responder.sv
// Single-outstanding DRAM model: fixed-latency reads, immediate writebacks.
// Optional address range checking is enabled with FIBER_DRAM_ADDR_CHECK_EN.
module fiber_dram_responder
  import fiber_dram_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_req_valid,
  output logic                  o_rd_req_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_data_valid,
  input  logic                  i_rd_data_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic                  o_busy,
  output logic                  o_addr_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_word;

  // Ready is a pure state decode so it reads 1 throughout reset; writes win collisions.
  assign o_wr_ready     = (state == IDLE);
  assign o_rd_req_ready = (state == IDLE) && !i_wr_valid;
  assign wr_fire        = i_wr_valid && o_wr_ready;
  assign rd_fire        = i_rd_req_valid && o_rd_req_ready;

  // The store is read at acceptance; no write can land while a read is outstanding.
  fiber_dram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk    (i_clk),
    .wr_en  (wr_en),
    .wr_idx (i_wr_addr[IDX_W-1:0]),
    .wr_data(i_wr_data),
    .rd_en  (rd_fire),
    .rd_idx (i_rd_addr[IDX_W-1:0]),
    .rd_data(mem_rdata)
  );

`ifdef FIBER_DRAM_ADDR_CHECK_EN
  logic wr_oor;
  logic rd_oor;
  logic rd_oor_q;

  assign wr_oor  = |i_wr_addr[ADDR_WIDTH-1:IDX_W];
  assign rd_oor  = |i_rd_addr[ADDR_WIDTH-1:IDX_W];
  assign wr_en   = wr_fire && !wr_oor;
  assign rd_word = rd_oor_q ? '1 : mem_rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_addr_err <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      if ((wr_fire && wr_oor) || (rd_fire && rd_oor)) o_addr_err <= 1'b1;
      if (rd_fire) rd_oor_q <= rd_oor;
    end
  end
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^{i_wr_addr[ADDR_WIDTH-1:IDX_W], i_rd_addr[ADDR_WIDTH-1:IDX_W]};
  assign wr_en          = wr_fire;
  assign rd_word        = mem_rdata;
  assign o_addr_err     = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      o_rd_data       <= '0;
      o_rd_data_valid <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_fire) begin
            cnt    <= CNT_LOAD;
            state  <= RD_WAIT;
            o_busy <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state           <= RD_RESP;
            o_rd_data       <= rd_word;
            o_rd_data_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (i_rd_data_ready) begin
            state           <= IDLE;
            o_rd_data_valid <= 1'b0;
            o_busy          <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          o_rd_data_valid <= 1'b0;
          o_busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fiber_dram_responder.sv
// Self-checking bench for fiber_dram_responder: vector table, scoreboard and corner-case sequences.
module tb_fiber_dram_responder;

`ifdef FIBER_DRAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [15:0] V05  = CHK ? 16'hBEEF : 16'h1111;
  localparam logic [15:0] V100 = CHK ? 16'hFFFF : 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] rd_addr;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready;
  logic [63:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        addr_err;

  logic [63:0] rd_addr1;
  logic        rd_req_valid1;
  logic        rd_req_ready1;
  logic [15:0] rd_data1;
  logic        rd_data_valid1;
  logic [63:0] wr_addr1;
  logic [15:0] wr_data1;
  logic        wr_valid1;
  logic        wr_ready1;
  logic        busy1;
  logic        addr_err1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic exp_err = 1'b0;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  fiber_dram_responder dut (
    .i_clk(clk), .i_reset(rst),
    .i_rd_addr(rd_addr), .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready),
    .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid), .i_rd_data_ready(rd_data_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_busy(busy), .o_addr_err(addr_err)
  );

  fiber_dram_responder #(.READ_LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_rd_addr(rd_addr1), .i_rd_req_valid(rd_req_valid1), .o_rd_req_ready(rd_req_ready1),
    .o_rd_data(rd_data1), .o_rd_data_valid(rd_data_valid1), .i_rd_data_ready(1'b1),
    .i_wr_addr(wr_addr1), .i_wr_data(wr_data1), .i_wr_valid(wr_valid1), .o_wr_ready(wr_ready1),
    .o_busy(busy1), .o_addr_err(addr_err1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every completed response handshake pops one expected word.
  always @(negedge clk) begin
    if (rd_data_valid && rd_data_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_valid", {63'd0, rd_data_valid}, 64'd0);
      else check("sb_rd_data", {48'd0, rd_data}, {48'd0, exp_q.pop_front()});
    end
  end

  task automatic do_write(input logic [63:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    check("wr_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic rd_accept(input logic [63:0] a, input logic [15:0] e, input bit push);
    int n = 0;
    @(negedge clk);
    rd_addr = a; rd_req_valid = 1'b1;
    while (!rd_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rd_req_ready) check("rd_accept_timeout", {63'd0, rd_req_ready}, 64'd1);
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1 rd_req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lat, input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!rd_data_valid && n < 20);
    check(nm, n, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = '0; rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
    rd_addr1 = '0; rd_req_valid1 = 1'b0;
    wr_addr1 = '0; wr_data1 = '0; wr_valid1 = 1'b0;

    vecs[0]  = '{1'b1, 64'h05,  16'hBEEF};
    vecs[1]  = '{1'b0, 64'h05,  16'hBEEF};
    vecs[2]  = '{1'b1, 64'h00,  16'hA5A5};
    vecs[3]  = '{1'b1, 64'hFF,  16'h5A5A};
    vecs[4]  = '{1'b0, 64'hFF,  16'h5A5A};
    vecs[5]  = '{1'b0, 64'h00,  16'hA5A5};
    vecs[6]  = '{1'b1, 64'h105, 16'h1111};
    vecs[7]  = '{1'b0, 64'h05,  V05};
    vecs[8]  = '{1'b0, 64'h100, V100};
    vecs[9]  = '{1'b1, 64'h33,  16'hFFFF};
    vecs[10] = '{1'b0, 64'h33,  16'hFFFF};
    vecs[11] = '{1'b1, 64'h33,  16'h0000};
    vecs[12] = '{1'b0, 64'h33,  16'h0000};

    // Reset values before any clock edge
    #1;
    check("rst_rd_valid", {63'd0, rd_data_valid}, 64'd0);
    check("rst_rd_data", {48'd0, rd_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_addr_err", {63'd0, addr_err}, 64'd0);
    check("rst_rd_req_ready", {63'd0, rd_req_ready}, 64'd1);
    check("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    check("rst_l1_addr_err", {63'd0, addr_err1}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Preload the latency-1 instance
    @(negedge clk);
    wr_addr1 = 64'h01; wr_data1 = 16'h0101; wr_valid1 = 1'b1;
    @(negedge clk);
    wr_addr1 = 64'h02; wr_data1 = 16'h0202;
    @(negedge clk);
    wr_valid1 = 1'b0;

    // Vector table: writes, reads with latency/pulse checks, wrap-around addresses
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        rd_accept(vecs[i].addr, vecs[i].data, 1'b1);
        wait_valid(4, $sformatf("vec%0d_latency", i));
        @(posedge clk);
        #1 check($sformatf("vec%0d_pulse", i), {63'd0, rd_data_valid}, 64'd0);
        check($sformatf("vec%0d_busy_clear", i), {63'd0, busy}, 64'd0);
      end
      if (CHK && vecs[i].addr >= 64'd256) exp_err = 1'b1;
      #1 check($sformatf("vec%0d_addr_err", i), {63'd0, addr_err}, {63'd0, exp_err});
    end

    // Same-cycle write/read collision on 0x10
    @(negedge clk);
    wr_addr = 64'h10; wr_data = 16'h1234; wr_valid = 1'b1;
    rd_addr = 64'h10; rd_req_valid = 1'b1;
    #1 check("coll_rd_blocked", {63'd0, rd_req_ready}, 64'd0);
    check("coll_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    #1 check("coll_rd_ready_next", {63'd0, rd_req_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back(16'h1234);
    #1 rd_req_valid = 1'b0;
    check("coll_busy", {63'd0, busy}, 64'd1);
    wait_valid(4, "coll_latency");
    @(posedge clk);
    #1 check("coll_pulse", {63'd0, rd_data_valid}, 64'd0);

    // Response back-pressure: held stable for 5 cycles
    rd_data_ready = 1'b0;
    rd_accept(64'h05, V05, 1'b1);
    wait_valid(4, "hold_latency");
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {63'd0, rd_data_valid}, 64'd1);
      check("hold_data", {48'd0, rd_data}, {48'd0, V05});
      check("hold_rd_req_ready", {63'd0, rd_req_ready}, 64'd0);
      check("hold_wr_ready", {63'd0, wr_ready}, 64'd0);
    end
    @(posedge clk);
    #1 rd_data_ready = 1'b1;
    @(posedge clk);
    #1 check("hold_release_valid", {63'd0, rd_data_valid}, 64'd0);
    check("hold_release_busy", {63'd0, busy}, 64'd0);

    // Reset two cycles into a read: response discarded
    rd_accept(64'h05, V05, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_valid", {63'd0, rd_data_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_data", {48'd0, rd_data}, 64'd0);
    check("midrst_addr_err", {63'd0, addr_err}, 64'd0);
    check("midrst_rd_req_ready", {63'd0, rd_req_ready}, 64'd1);
    check("midrst_wr_ready", {63'd0, wr_ready}, 64'd1);
    exp_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (8) begin
        @(posedge clk);
        #1 if (rd_data_valid) seen++;
      end
      check("midrst_no_valid_after", seen, 0);
      check("midrst_busy_after", {63'd0, busy}, 64'd0);
    end

    // Store contents survive reset
    rd_accept(64'h05, V05, 1'b1);
    wait_valid(4, "post_rst_latency");
    @(posedge clk);
    #1 check("post_rst_pulse", {63'd0, rd_data_valid}, 64'd0);

    // READ_LATENCY=1 back-to-back reads with request held high
    @(negedge clk);
    rd_addr1 = 64'h01; rd_req_valid1 = 1'b1;
    #1 check("l1_ready0", {63'd0, rd_req_ready1}, 64'd1);
    @(posedge clk);
    #1 rd_addr1 = 64'h02;
    check("l1_wait_valid", {63'd0, rd_data_valid1}, 64'd0);
    check("l1_wait_ready", {63'd0, rd_req_ready1}, 64'd0);
    @(posedge clk);
    #1 check("l1_resp1_valid", {63'd0, rd_data_valid1}, 64'd1);
    check("l1_resp1_data", {48'd0, rd_data1}, 64'h0101);
    @(posedge clk);
    #1 check("l1_idle_valid", {63'd0, rd_data_valid1}, 64'd0);
    check("l1_idle_ready", {63'd0, rd_req_ready1}, 64'd1);
    @(posedge clk);
    #1 rd_req_valid1 = 1'b0;
    check("l1_wait2_valid", {63'd0, rd_data_valid1}, 64'd0);
    check("l1_wait2_busy", {63'd0, busy1}, 64'd1);
    @(posedge clk);
    #1 check("l1_resp2_valid", {63'd0, rd_data_valid1}, 64'd1);
    check("l1_resp2_data", {48'd0, rd_data1}, 64'h0202);
    @(posedge clk);
    #1 check("l1_resp2_pulse", {63'd0, rd_data_valid1}, 64'd0);
    check("l1_wr_ready", {63'd0, wr_ready1}, 64'd1);

    repeat (2) @(posedge clk);
    #1 check("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
